// File: rtl/mov_pkg.sv
// Shared types and default sizing for the mov_unit register/port move sequencer.
package mov_pkg;

  localparam int NUM_REGS_DEF  = 4;
  localparam int NUM_PORTS_DEF = 1;
  localparam int OPW_DEF       = 6;

  typedef enum logic [1:0] {
    MODE_MOV  = 2'b00,
    MODE_MOVI = 2'b01,
    MODE_XCHG = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_XFER,
    ST_X1,
    ST_X2,
    ST_X3,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/mov_unit_if.sv
// Request and datapath-enable bundle between a sequencer client and mov_unit.
interface mov_unit_if
  import mov_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int OPW       = OPW_DEF
) ();

  logic                 donefetch;
  logic                 start;
  logic [1:0]           mode;
  logic [OPW-1:0]       parameter1;
  logic [OPW-1:0]       parameter2;
  logic [NUM_REGS-1:0]  r_in_en;
  logic [NUM_REGS-1:0]  r_out_en;
  logic [NUM_PORTS-1:0] p_in_en;
  logic [NUM_PORTS-1:0] p_out_en;
  logic                 imm_out_en;
  logic                 tmp_in_en;
  logic                 tmp_out_en;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output donefetch, start, mode, parameter1, parameter2,
    input  r_in_en, r_out_en, p_in_en, p_out_en,
    input  imm_out_en, tmp_in_en, tmp_out_en, busy, done, err
  );

  modport slave (
    input  donefetch, start, mode, parameter1, parameter2,
    output r_in_en, r_out_en, p_in_en, p_out_en,
    output imm_out_en, tmp_in_en, tmp_out_en, busy, done, err
  );

endinterface

// File: rtl/mov_operand_decode.sv
// Maps an operand code to a register one-hot, a port one-hot and a legality flag.
module mov_operand_decode
  import mov_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int OPW       = OPW_DEF
) (
  input  logic [OPW-1:0]       code,
  output logic [NUM_REGS-1:0]  reg_oh,
  output logic [NUM_PORTS-1:0] port_oh,
  output logic                 valid
);

  always_comb begin
    reg_oh  = '0;
    port_oh = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_oh[i] = (code == OPW'(i));
    end
    // Ports follow directly after the register codes.
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_oh[i] = (code == OPW'(NUM_REGS + i));
    end
    valid = (|reg_oh) | (|port_oh);
  end

endmodule

// File: rtl/mov_unit.sv
// MOV/MOVI/XCHG transfer sequencer driving register, port, immediate and temp enables.
// Exchange support (states X1..X3, tmp enables, mode 10) is built only when MOV_XCHG_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start, operands captured on start
// DECODE | legality check of captured operands and mode
// XFER   | single-cycle MOV/MOVI transfer
// X1     | src -> tmp
// X2     | dst -> src
// X3     | tmp -> dst
// DONE   | one-cycle completion pulse
// ERR    | one-cycle completion pulse with err, no enables
module mov_unit
  import mov_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int OPW       = OPW_DEF
) (
  input logic       clk,
  input logic       rst,
  mov_unit_if.slave bus
);

  state_t               state_q, state_d;
  mode_t                mode_q;
  logic [OPW-1:0]       dst_q, src_q;
  logic [NUM_REGS-1:0]  dst_reg, src_reg;
  logic [NUM_PORTS-1:0] dst_port, src_port;
  logic                 dst_valid, src_valid;

  logic [NUM_REGS-1:0]  r_in, r_out;
  logic [NUM_PORTS-1:0] p_in, p_out;
  logic                 imm_out, tmp_in, tmp_out;
  logic                 busy, done, err;

  mov_operand_decode #(
    .NUM_REGS (NUM_REGS),
    .NUM_PORTS(NUM_PORTS),
    .OPW      (OPW)
  ) u_dst_decode (
    .code   (dst_q),
    .reg_oh (dst_reg),
    .port_oh(dst_port),
    .valid  (dst_valid)
  );

  mov_operand_decode #(
    .NUM_REGS (NUM_REGS),
    .NUM_PORTS(NUM_PORTS),
    .OPW      (OPW)
  ) u_src_decode (
    .code   (src_q),
    .reg_oh (src_reg),
    .port_oh(src_port),
    .valid  (src_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MOV;
      dst_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.start && !bus.donefetch) begin
        mode_q <= mode_t'(bus.mode);
        dst_q  <= bus.parameter1;
        src_q  <= bus.parameter2;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // MOVI ignores the source code, so an illegal src is harmless there.
        if (!dst_valid || mode_q == MODE_RSVD || (mode_q != MODE_MOVI && !src_valid)) begin
          state_d = ST_ERR;
        end else begin
          case (mode_q)
            MODE_MOV, MODE_MOVI: state_d = ST_XFER;
`ifdef MOV_XCHG_EN
            MODE_XCHG:           state_d = (dst_q == src_q) ? ST_DONE : ST_X1;
`endif
            default:             state_d = ST_ERR;
          endcase
        end
      end
      ST_XFER: state_d = ST_DONE;
`ifdef MOV_XCHG_EN
      ST_X1:   state_d = ST_X2;
      ST_X2:   state_d = ST_X3;
      ST_X3:   state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.donefetch) state_d = ST_IDLE;
  end

  always_comb begin
    r_in    = '0;
    r_out   = '0;
    p_in    = '0;
    p_out   = '0;
    imm_out = 1'b0;
    tmp_in  = 1'b0;
    tmp_out = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_XFER: begin
        r_in = dst_reg;
        p_in = dst_port;
        if (mode_q == MODE_MOVI) begin
          imm_out = 1'b1;
        end else begin
          r_out = src_reg;
          p_out = src_port;
        end
      end
`ifdef MOV_XCHG_EN
      ST_X1: begin
        r_out  = src_reg;
        p_out  = src_port;
        tmp_in = 1'b1;
      end
      ST_X2: begin
        r_out = dst_reg;
        p_out = dst_port;
        r_in  = src_reg;
        p_in  = src_port;
      end
      ST_X3: begin
        tmp_out = 1'b1;
        r_in    = dst_reg;
        p_in    = dst_port;
      end
`endif
      ST_DONE: done = 1'b1;
      ST_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.r_in_en    = r_in;
  assign bus.r_out_en   = r_out;
  assign bus.p_in_en    = p_in;
  assign bus.p_out_en   = p_out;
  assign bus.imm_out_en = imm_out;
  assign bus.tmp_in_en  = tmp_in;
  assign bus.tmp_out_en = tmp_out;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;

endmodule

// File: tb/tb_mov_unit.sv
// Self-checking bench for mov_unit; expectations follow MOV_XCHG_EN the same way the design does.
module tb_mov_unit;

  localparam int NR  = 4;
  localparam int NP  = 1;
  localparam int W   = 6;
  localparam int IMM = -1;
  localparam int TMP = -2;
`ifdef MOV_XCHG_EN
  localparam bit XCHG_EN = 1'b1;
`else
  localparam bit XCHG_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NR-1:0] r_in;
    logic [NR-1:0] r_out;
    logic [NP-1:0] p_in;
    logic [NP-1:0] p_out;
    logic          imm;
    logic          tin;
    logic          tout;
    logic          busy;
    logic          done;
    logic          err;
  } obs_t;

  typedef struct {
    int    mode;
    int    dst;
    int    src;
    int    lat;
    bit    err;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  obs_t trace[$];
  vec_t vecs[10];

  mov_unit_if #(.NUM_REGS(NR), .NUM_PORTS(NP), .OPW(W)) bus ();

  mov_unit #(.NUM_REGS(NR), .NUM_PORTS(NP), .OPW(W)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.r_in  = bus.r_in_en;
    o.r_out = bus.r_out_en;
    o.p_in  = bus.p_in_en;
    o.p_out = bus.p_out_en;
    o.imm   = bus.imm_out_en;
    o.tin   = bus.tmp_in_en;
    o.tout  = bus.tmp_out_en;
    o.busy  = bus.busy;
    o.done  = bus.done;
    o.err   = bus.err;
    return o;
  endfunction

  function automatic bit legal(int c);
    return (c >= 0) && (c < NR + NP);
  endfunction

  function automatic obs_t drive_from(obs_t o, int c);
    obs_t r = o;
    if (c == IMM) r.imm = 1'b1;
    else if (c == TMP) r.tout = 1'b1;
    else if (c < NR) r.r_out = r.r_out | (NR'(1) << c);
    else r.p_out = r.p_out | (NP'(1) << (c - NR));
    return r;
  endfunction

  function automatic obs_t load_to(obs_t o, int c);
    obs_t r = o;
    if (c == TMP) r.tin = 1'b1;
    else if (c < NR) r.r_in = r.r_in | (NR'(1) << c);
    else r.p_in = r.p_in | (NP'(1) << (c - NR));
    return r;
  endfunction

  // Reference: a list of (from, to) moves per operation, one move per cycle.
  task automatic build_trace(input int mode, input int dst, input int src);
    obs_t o;
    int   from_q[$];
    int   to_q[$];
    bit   bad;
    trace.delete();
    o = '0;
    o.busy = 1'b1;
    trace.push_back(o);
    bad = !legal(dst) || mode == 3 || (mode != 1 && !legal(src)) || (mode == 2 && !XCHG_EN);
    if (bad) begin
      o.done = 1'b1;
      o.err  = 1'b1;
      trace.push_back(o);
      return;
    end
    if (mode == 0) begin
      from_q.push_back(src); to_q.push_back(dst);
    end else if (mode == 1) begin
      from_q.push_back(IMM); to_q.push_back(dst);
    end else if (src != dst) begin
      from_q.push_back(src); to_q.push_back(TMP);
      from_q.push_back(dst); to_q.push_back(src);
      from_q.push_back(TMP); to_q.push_back(dst);
    end
    foreach (from_q[k]) begin
      o = '0;
      o.busy = 1'b1;
      o = drive_from(o, from_q[k]);
      o = load_to(o, to_q[k]);
      trace.push_back(o);
    end
    o = '0;
    o.busy = 1'b1;
    o.done = 1'b1;
    trace.push_back(o);
  endtask

  task automatic check(input string nm, input obs_t e);
    obs_t a = sample();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", nm, a, e);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", nm, a, e);
    end
  endtask

  task automatic launch(input int mode, input int dst, input int src);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.mode       = 2'(mode);
    bus.parameter1 = W'(dst);
    bus.parameter2 = W'(src);
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.mode       = 2'($urandom);
    bus.parameter1 = W'($urandom);
    bus.parameter2 = W'($urandom);
  endtask

  // Walks the expected trace; stray start pulses while busy must be ignored.
  task automatic follow(input string nm, input int stop_at, output int done_cyc, output bit err_seen);
    obs_t a;
    done_cyc = 0;
    err_seen = 1'b0;
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge clk);
      a = sample();
      check(nm, trace[i]);
      if (a.done && done_cyc == 0) begin
        done_cyc = i + 1;
        err_seen = a.err;
      end
      if (stop_at == i + 1) begin
        bus.start = 1'b0;
        return;
      end
      if (i < trace.size() - 1) begin
        bus.start      = 1'($urandom_range(0, 1));
        bus.mode       = 2'($urandom);
        bus.parameter1 = W'($urandom_range(0, 5));
        bus.parameter2 = W'($urandom_range(0, 5));
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    check({nm, "_idle"}, '0);
  endtask

  initial begin
    int dc;
    bit es;
    int m, d, s;

    vecs[0] = '{0, 2, 1, 3, 1'b0, "mov_r2_r1"};
    vecs[1] = '{1, 4, 63, 3, 1'b0, "movi_p0"};
    vecs[2] = '{0, 5, 0, 2, 1'b1, "mov_bad_dst"};
    vecs[3] = XCHG_EN ? '{2, 0, 3, 5, 1'b0, "xchg_r0_r3"} : '{2, 0, 3, 2, 1'b1, "xchg_r0_r3"};
    vecs[4] = XCHG_EN ? '{2, 2, 2, 2, 1'b0, "xchg_same"}  : '{2, 2, 2, 2, 1'b1, "xchg_same"};
    vecs[5] = '{3, 1, 1, 2, 1'b1, "mode_rsvd"};
    vecs[6] = '{0, 3, 3, 3, 1'b0, "mov_same_reg"};
    vecs[7] = '{0, 0, 4, 3, 1'b0, "mov_r0_p0"};
    vecs[8] = '{0, 1, 63, 2, 1'b1, "mov_bad_src"};
    vecs[9] = '{1, 63, 0, 2, 1'b1, "movi_bad_dst"};

    bus.donefetch  = 1'b0;
    bus.start      = 1'b0;
    bus.mode       = 2'b00;
    bus.parameter1 = '0;
    bus.parameter2 = '0;
    #3;
    check("reset_outputs", '0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", '0);

    foreach (vecs[i]) begin
      launch(vecs[i].mode, vecs[i].dst, vecs[i].src);
      build_trace(vecs[i].mode, vecs[i].dst, vecs[i].src);
      follow(vecs[i].name, 0, dc, es);
      check_int({vecs[i].name, "_latency"}, dc, vecs[i].lat);
      check_int({vecs[i].name, "_err"}, int'(es), int'(vecs[i].err));
    end

    // donefetch mid-sequence: X2 of an exchange, or XFER when exchange is absent
    if (XCHG_EN) begin
      launch(2, 0, 3);
      build_trace(2, 0, 3);
      follow("abort_x2", 3, dc, es);
    end else begin
      launch(0, 2, 1);
      build_trace(0, 2, 1);
      follow("abort_xfer", 2, dc, es);
    end
    bus.donefetch = 1'b1;
    @(posedge clk);
    #1 bus.donefetch = 1'b0;
    @(negedge clk);
    check("abort_no_done", '0);
    @(negedge clk);
    check("abort_idle", '0);

    // donefetch outranks start in IDLE
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.donefetch  = 1'b1;
    bus.mode       = 2'b00;
    bus.parameter1 = W'(2);
    bus.parameter2 = W'(1);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.donefetch = 1'b0;
    @(negedge clk);
    check("fetch_over_start", '0);

    // asynchronous reset while in XFER
    launch(0, 2, 1);
    build_trace(0, 2, 1);
    follow("rst_xfer_pre", 2, dc, es);
    #2 rst = 1'b1;
    #1 check("rst_xfer_async", '0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst_xfer_after", '0);
    launch(vecs[0].mode, vecs[0].dst, vecs[0].src);
    build_trace(vecs[0].mode, vecs[0].dst, vecs[0].src);
    follow("rst_recover", 0, dc, es);
    check_int("rst_recover_latency", dc, 3);

    for (int n = 0; n < 150; n++) begin
      m = $urandom_range(0, 3);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
      s = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
      launch(m, d, s);
      build_trace(m, d, s);
      follow("random", 0, dc, es);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mov_unit.md
MOV_UNIT -- requirements
Module: mov_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4: number of general registers addressable by operand code.
REQ-002 SHALL have parameter NUM_PORTS, default 1: number of I/O ports addressable by operand code.
REQ-003 SHALL have parameter OPW, default 6: operand code width; NUM_REGS+NUM_PORTS <= 2**OPW.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port donefetch, input, 1: synchronous abort to IDLE.
REQ-007 SHALL have port start, input, 1: request pulse, sampled in IDLE only.
REQ-008 SHALL have port mode, input, 2: 00 MOV, 01 MOVI, 10 XCHG, 11 reserved.
REQ-009 SHALL have ports parameter1 and parameter2, input, OPW each: destination and source operand codes.
REQ-010 SHALL have ports r_in_en and r_out_en, output, NUM_REGS each: register load and drive enables.
REQ-011 SHALL have ports p_in_en and p_out_en, output, NUM_PORTS each: port load and drive enables.
REQ-012 SHALL have ports imm_out_en, tmp_in_en and tmp_out_en, output, 1 each: immediate drive, temp load, temp drive.
REQ-013 SHALL have ports busy, done and err, output, 1 each.

Function
REQ-014 Operand codes: 0..NUM_REGS-1 select register c; NUM_REGS..NUM_REGS+NUM_PORTS-1 select port c-NUM_REGS; all other codes are illegal.
REQ-015 FSM states: IDLE, DECODE, XFER, X1, X2, X3, DONE, ERR.
REQ-016 IDLE with start=1: capture mode, parameter1 and parameter2 into internal registers; next state DECODE.
REQ-017 DECODE goes to ERR on: illegal dst; illegal src when mode!=MOVI; mode=11.
REQ-018 DECODE otherwise: MOV/MOVI go to XFER; XCHG with src==dst goes to DONE; other XCHG goes to X1.
REQ-019 XFER: assert the in-enable of dst together with the out-enable of src (MOV) or with imm_out_en (MOVI); next state DONE.
REQ-020 XCHG sequence: X1 asserts src out-enable + tmp_in_en; X2 asserts dst out-enable + src in-enable; X3 asserts tmp_out_en + dst in-enable; then DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE. ERR: done=1 and err=1 for one cycle, no enables asserted, then IDLE.
REQ-022 Latency from the start cycle to done: MOV/MOVI 3 cycles, XCHG 5 cycles, XCHG with src==dst 2 cycles, error 2 cycles.
REQ-023 All outputs SHALL be decoded only from the state register and the captured operands, never from live inputs; no latches.
REQ-024 Enable vectors are one-hot or zero in every state; MOV with src==dst asserts both enables of the same register.
REQ-025 busy=1 in every state except IDLE; start while busy SHALL be ignored, with no queueing.
REQ-026 donefetch=1 in any state: next state IDLE, all enables low, no done pulse; donefetch has priority over start.

Reset
REQ-027 rst=1 asynchronously forces state IDLE and clears the captured operands; every output reads 0, including mid-transfer.

Configuration
REQ-028 Macro MOV_XCHG_EN defined: XCHG, X1..X3, the tmp_* enables and mode 10 operate as specified above.
REQ-029 MOV_XCHG_EN undefined: X1..X3 are not built, tmp_in_en and tmp_out_en are tied to 0, and mode 10 takes the ERR path.

Structure
REQ-030 Package mov_pkg SHALL hold the mode enum, the state enum, and the default values of NUM_REGS, NUM_PORTS and OPW.
REQ-031 Sub-module mov_operand_decode (code -> reg one-hot, port one-hot, valid) SHALL be instantiated twice, once for dst and once for src.

Verification
REQ-032 MOV, dst=2, src=1, defaults: at cycle+2 r_in_en=0100 and r_out_en=0010 for one cycle; done at cycle+3.
REQ-033 MOVI, dst=4 (P0): at cycle+2 p_in_en[0]=1 and imm_out_en=1; done at cycle+3; parameter2=63 does not raise err.
REQ-034 MOV, dst=5 (illegal): done=1 and err=1 at cycle+2; no enable pulses at any point.
REQ-035 XCHG, dst=0, src=3, with MOV_XCHG_EN: X1/X2/X3 enables in order per REQ-020 on cycles +2..+4; done at cycle+5. Without the macro: err at cycle+2.
REQ-036 Abort and reset: donefetch in X2 returns to IDLE with no done; rst during XFER clears all outputs immediately; start while busy is ignored.
